vector_dac_driver: RTL and testbench

Parametrised N-channel DAC output stage. Sits between top_vector_display and the per-axis dac modules/Pmod pins.
- Accepts beam points over a valid/ready handshake.
- Holds each point on the DAC bus for a programmable dwell so the analog output settles.
- Parks all channels at midscale during a post-reset startup window.
- Generalises the fixed single 8-bit X path to N_CH channels of CH_WIDTH bits.

---
 rtl/vector_dac_pkg.sv | 14 +
 rtl/vector_dac_driver_if.sv | 36 +++
 rtl/vector_dac_dwell_cnt.sv | 29 ++
 rtl/vector_dac_driver.sv | 135 +++++++++++++
 tb/tb_vector_dac_driver.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/vector_dac_pkg.sv
// Shared types and helpers for the vector DAC output stage.
// Optional feature macro: VECTOR_DAC_BLANK_EN (step-magnitude blanking output).
package vector_dac_pkg;

    typedef enum logic [1:0] {ST_START, ST_IDLE, ST_HOLD} state_t;

    localparam int unsigned START_CYCLES_DEFAULT = 256;

    // Midscale code for an unsigned DAC of the given width.
    function automatic int unsigned midscale(input int unsigned width);
        return 32'd1 << (width - 1);
    endfunction

endpackage

// File: rtl/vector_dac_driver_if.sv
// Point-in / DAC-out bundle between the display core and the DAC driver.
// Optional feature macro: VECTOR_DAC_BLANK_EN adds the blank signal.
interface vector_dac_driver_if #(
    parameter int unsigned CH_WIDTH = 8,
    parameter int unsigned N_CH     = 2,
    parameter int unsigned DWELL_W  = 8
);
    logic                       enable;
    logic [N_CH*CH_WIDTH-1:0]   pt_data;
    logic                       pt_valid;
    logic                       pt_ready;
    logic [DWELL_W-1:0]         dwell;
    logic [N_CH*CH_WIDTH-1:0]   dac_out;
    logic                       dac_strobe;
    logic                       busy;
`ifdef VECTOR_DAC_BLANK_EN
    logic                       blank;
`endif

    modport master (
        output enable, pt_data, pt_valid, dwell,
`ifdef VECTOR_DAC_BLANK_EN
        input  blank,
`endif
        input  pt_ready, dac_out, dac_strobe, busy
    );

    modport slave (
        input  enable, pt_data, pt_valid, dwell,
`ifdef VECTOR_DAC_BLANK_EN
        output blank,
`endif
        output pt_ready, dac_out, dac_strobe, busy
    );

endinterface

// File: rtl/vector_dac_dwell_cnt.sv
// Loadable saturating down-counter with a zero flag.
// Optional feature macro VECTOR_DAC_BLANK_EN does not affect this block.
module vector_dac_dwell_cnt #(
    parameter int unsigned    WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic             zero
);
    logic [WIDTH-1:0] cnt_q;

    // Load has priority; decrement stops at zero instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= RESET_VAL;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_q <= cnt_q - WIDTH'(1);
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/vector_dac_driver.sv
// N-channel DAC output stage: accepts beam points over valid/ready, holds each
// for a programmable dwell, and parks all channels at midscale after reset.
// Optional feature macro: VECTOR_DAC_BLANK_EN adds the blank output, raised
// for points whose per-channel step exceeds BLANK_THRESH.
module vector_dac_driver
    import vector_dac_pkg::*;
#(
    parameter int unsigned CH_WIDTH     = 8,
    parameter int unsigned N_CH         = 2,
    parameter int unsigned DWELL_W      = 8,
`ifdef VECTOR_DAC_BLANK_EN
    parameter int unsigned BLANK_THRESH = 32,
`endif
    parameter int unsigned START_CYCLES = START_CYCLES_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    vector_dac_driver_if.slave bus
);
    localparam int unsigned W       = N_CH * CH_WIDTH;
    localparam int unsigned START_W = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;
    localparam logic [CH_WIDTH-1:0] MID      = CH_WIDTH'(midscale(CH_WIDTH));
    localparam logic [W-1:0]        MID_ALL  = {N_CH{MID}};
    localparam logic [START_W-1:0]  START_INIT = START_W'(START_CYCLES - 1);

    state_t               state;
    logic [W-1:0]         dac_q;
    logic                 strobe_q;
    logic                 ready;
    logic                 accept;
    logic                 start_zero;
    logic                 dwell_zero;
    logic [DWELL_W-1:0]   dwell_load;
    logic                 step_big;

    // Ready is combinational so enable takes effect in the same cycle.
    always_comb begin
        ready = 1'b0;
        case (state)
            ST_IDLE: ready = bus.enable;
            ST_HOLD: ready = bus.enable & dwell_zero;
            default: ready = 1'b0;
        endcase
    end

    assign accept     = bus.pt_valid & ready;
    // A dwell of 0 behaves as 1: the counter starts already at zero.
    assign dwell_load = (bus.dwell == '0) ? '0 : bus.dwell - DWELL_W'(1);

    vector_dac_dwell_cnt #(
        .WIDTH     (START_W),
        .RESET_VAL (START_INIT)
    ) u_start_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (1'b0),
        .load_val ('0),
        .dec      (state == ST_START),
        .zero     (start_zero)
    );

    vector_dac_dwell_cnt #(
        .WIDTH     (DWELL_W),
        .RESET_VAL ('0)
    ) u_dwell_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (accept),
        .load_val (dwell_load),
        .dec      (state == ST_HOLD),
        .zero     (dwell_zero)
    );

`ifdef VECTOR_DAC_BLANK_EN
    logic signed [CH_WIDTH:0] diff;
    logic        [CH_WIDTH:0] mag;
    logic                     blank_q;

    // Flag a large jump on any channel between the held code and the new point.
    always_comb begin
        step_big = 1'b0;
        diff     = '0;
        mag      = '0;
        for (int i = 0; i < int'(N_CH); i++) begin
            diff = $signed({1'b0, bus.pt_data[i*CH_WIDTH +: CH_WIDTH]})
                 - $signed({1'b0, dac_q[i*CH_WIDTH +: CH_WIDTH]});
            mag  = diff[CH_WIDTH] ? (CH_WIDTH+1)'(-diff) : (CH_WIDTH+1)'(diff);
            if (32'(mag) > BLANK_THRESH) begin
                step_big = 1'b1;
            end
        end
    end
`else
    assign step_big = 1'b0;
`endif

    // Control FSM with registered DAC code, strobe and blank.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_START;
            dac_q    <= MID_ALL;
            strobe_q <= 1'b0;
`ifdef VECTOR_DAC_BLANK_EN
            blank_q  <= 1'b1;
`endif
        end else begin
            strobe_q <= accept;
            if (accept) begin
                dac_q <= bus.pt_data;
`ifdef VECTOR_DAC_BLANK_EN
                blank_q <= step_big;
`endif
            end
            case (state)
                ST_START: if (start_zero) state <= ST_IDLE;
                ST_IDLE:  if (accept) state <= ST_HOLD;
                ST_HOLD:  if (dwell_zero && !accept) state <= ST_IDLE;
                default:  state <= ST_START;
            endcase
        end
    end

    assign bus.pt_ready   = ready;
    assign bus.dac_out    = dac_q;
    assign bus.dac_strobe = strobe_q;
    assign bus.busy       = (state != ST_IDLE);
`ifdef VECTOR_DAC_BLANK_EN
    assign bus.blank      = blank_q;
`else
    // Comparator is compiled out in this build.
    logic unused_step_big;
    assign unused_step_big = step_big;
`endif

endmodule

// File: tb/tb_vector_dac_driver.sv
// Self-checking bench for vector_dac_driver (2 x 8-bit channels).
// Optional feature macro: VECTOR_DAC_BLANK_EN enables the blank checks.
module tb_vector_dac_driver;
    localparam int START = 256;
    localparam logic [15:0] MID = 16'h8080;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    vector_dac_driver_if #(.CH_WIDTH(8), .N_CH(2), .DWELL_W(8)) bus ();

    vector_dac_driver #(
        .CH_WIDTH     (8),
        .N_CH         (2),
        .DWELL_W      (8),
        .START_CYCLES (START)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: time-stamp view of the driver.
    int          cyc;       // cycles since reset release
    int          last_acc;  // cycle of the latest accept, -1 if none
    int          last_d;    // effective dwell of that accept
    logic [15:0] m_dac;
    logic        m_strobe;
    logic        m_blank;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (cycle %0d): got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        cyc      = 0;
        last_acc = -1;
        last_d   = 1;
        m_dac    = MID;
        m_strobe = 1'b0;
        m_blank  = 1'b1;
    endtask

    function automatic logic big_step(input logic [15:0] nw, input logic [15:0] cur);
        for (int ch = 0; ch < 2; ch++) begin
            int a = int'(nw[ch*8 +: 8]);
            int b = int'(cur[ch*8 +: 8]);
            int m = (a > b) ? a - b : b - a;
            if (m > 32) return 1'b1;
        end
        return 1'b0;
    endfunction

    // One clock cycle: starts #1 after a rising edge, checks at the falling edge.
    task automatic step(input logic v, input logic [15:0] d, input logic [7:0] dw,
                        input logic en, output logic acc, output logic stb,
                        output logic [15:0] dout);
        logic e_ready, e_busy, m_acc;
        bus.pt_valid = v;
        bus.pt_data  = d;
        bus.dwell    = dw;
        bus.enable   = en;
        @(negedge clk);
        e_ready = en && (cyc >= START) && (last_acc < 0 || cyc >= last_acc + last_d);
        e_busy  = (cyc < START) || (last_acc >= 0 && cyc <= last_acc + last_d);
        check("pt_ready", 32'(bus.pt_ready), 32'(e_ready));
        check("busy", 32'(bus.busy), 32'(e_busy));
        check("dac_out", 32'(bus.dac_out), 32'(m_dac));
        check("dac_strobe", 32'(bus.dac_strobe), 32'(m_strobe));
`ifdef VECTOR_DAC_BLANK_EN
        check("blank", 32'(bus.blank), 32'(m_blank));
`endif
        acc  = v && bus.pt_ready;
        stb  = bus.dac_strobe;
        dout = bus.dac_out;
        m_acc    = v && e_ready;
        m_strobe = m_acc;
        if (m_acc) begin
            m_blank  = big_step(d, m_dac);
            m_dac    = d;
            last_acc = cyc;
            last_d   = (dw == 8'd0) ? 1 : int'(dw);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Offer a point until the DUT takes it; returns the accept cycle.
    task automatic send(input logic [15:0] d, input logic [7:0] dw, input int bound,
                        output int acc_cyc);
        logic acc, stb;
        logic [15:0] dout;
        acc_cyc = -1;
        for (int i = 0; i < bound; i++) begin
            acc_cyc = cyc;
            step(1'b1, d, dw, 1'b1, acc, stb, dout);
            if (acc) return;
        end
        acc_cyc = -1;
        check("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle(input int n);
        logic acc, stb;
        logic [15:0] dout;
        for (int i = 0; i < n; i++) step(1'b0, 16'h0, 8'd1, 1'b1, acc, stb, dout);
    endtask

    typedef struct {
        logic [15:0] data;
        logic [7:0]  dwell;
        int          gap;   // cycles since the previous strobe
    } vec_t;

    initial begin
        vec_t tbl [9];
        int acc_cyc, k, s, prev_stb, nstb, c;
        logic acc, stb;
        logic [15:0] dout;

        tbl[0] = '{16'h1020, 8'd4, 0};
        tbl[1] = '{16'h3040, 8'd4, 4};
        tbl[2] = '{16'h5060, 8'd4, 4};
        tbl[3] = '{16'h0A0B, 8'd0, 4};
        tbl[4] = '{16'h0C0D, 8'd0, 1};
        tbl[5] = '{16'h0E0F, 8'd1, 1};
        tbl[6] = '{16'h1111, 8'd1, 1};
        tbl[7] = '{16'h2222, 8'd3, 1};
        tbl[8] = '{16'h3333, 8'd2, 3};

        rst = 1'b1;
        bus.pt_valid = 1'b1;
        bus.pt_data  = 16'h0;
        bus.dwell    = 8'd1;
        bus.enable   = 1'b1;
        model_reset();
        #2;
        check("rst_dac_out", 32'(bus.dac_out), 32'(MID));
        check("rst_busy", 32'(bus.busy), 32'd1);
        check("rst_pt_ready", 32'(bus.pt_ready), 32'd0);
        check("rst_strobe", 32'(bus.dac_strobe), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        model_reset();

        // Startup window with valid held high.
        send(16'h1234, 8'd1, 300, acc_cyc);
        check("first_accept_cycle", 32'(acc_cyc), 32'd256);
        check("first_strobe", 32'(bus.dac_strobe), 32'd1);
        check("first_dac", 32'(bus.dac_out), 32'h1234);
        idle(3);

        // Back-to-back table points.
        k = 0; s = 0; prev_stb = -1;
        for (int i = 0; i < 200 && s < 9; i++) begin
            c = cyc;
            if (k < 9) step(1'b1, tbl[k].data, tbl[k].dwell, 1'b1, acc, stb, dout);
            else       step(1'b0, 16'h0, 8'd1, 1'b1, acc, stb, dout);
            if (acc) k++;
            if (stb) begin
                check("tbl_data", 32'(dout), 32'(tbl[s].data));
                if (s > 0) check("tbl_gap", 32'(c - prev_stb), 32'(tbl[s].gap));
                prev_stb = c;
                s++;
            end
        end
        check("tbl_all_strobed", 32'(s), 32'd9);
        idle(4);

        // Enable dropped two cycles into a 10-cycle hold.
        send(16'hABCD, 8'd10, 20, acc_cyc);
        step(1'b0, 16'h0, 8'd10, 1'b1, acc, stb, dout);
        nstb = 0;
        for (int i = 0; i < 14; i++) begin
            step(1'b1, 16'h7777, 8'd1, 1'b0, acc, stb, dout);
            if (stb) nstb++;
        end
        check("en_no_strobe", 32'(nstb), 32'd0);
        check("en_dac_hold", 32'(bus.dac_out), 32'hABCD);
        check("en_busy_low", 32'(bus.busy), 32'd0);

        // Asynchronous reset in the middle of a hold.
        send(16'h5A5A, 8'd10, 20, acc_cyc);
        idle(3);
        #2 rst = 1'b1;
        #1;
        check("midhold_rst_dac", 32'(bus.dac_out), 32'(MID));
        check("midhold_rst_busy", 32'(bus.busy), 32'd1);
        check("midhold_rst_ready", 32'(bus.pt_ready), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        send(16'h0102, 8'd2, 300, acc_cyc);
        check("restart_accept_cycle", 32'(acc_cyc), 32'd256);

`ifdef VECTOR_DAC_BLANK_EN
        idle(3);
        send(16'h8010, 8'd3, 20, acc_cyc);
        idle(3);
        send(16'h8060, 8'd3, 20, acc_cyc);
        for (int i = 0; i < 3; i++) begin
            check("blank_big_step", 32'(bus.blank), 32'd1);
            idle(1);
        end
        send(16'h8070, 8'd3, 20, acc_cyc);
        check("blank_small_step", 32'(bus.blank), 32'd0);
        idle(3);
`endif

        // Random traffic against the model, with one reset mid-run.
        for (int i = 0; i < 1500; i++) begin
            if (i == 700) begin
                #2 rst = 1'b1;
                @(posedge clk);
                #1 rst = 1'b0;
                model_reset();
            end
            step($urandom_range(0, 3) != 0, 16'($urandom), 8'($urandom_range(0, 5)),
                 $urandom_range(0, 7) != 0, acc, stb, dout);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
